// File: rtl/reg_file_scoreboard_if.sv
// Bus bundle for reg_file_scoreboard.
//   master : drives read/write addresses, write data, issue and flush controls
//   slave  : returns read data, per-port busy flags and the registered busy count
interface reg_file_scoreboard_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 2
);
  localparam int unsigned AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   rdAddr;
  logic [NRD*XLEN-1:0] rdData;
  logic [NRD-1:0]      rdBusy;
  logic [NWR-1:0]      wrEn;
  logic [NWR*AW-1:0]   wrAddr;
  logic [NWR*XLEN-1:0] wrData;
  logic                issueEn;
  logic [AW-1:0]       issueAddr;
  logic                flushEn;
  logic [AW:0]         busyCount;

  modport master (
    output rdAddr, wrEn, wrAddr, wrData, issueEn, issueAddr, flushEn,
    input  rdData, rdBusy, busyCount
  );

  modport slave (
    input  rdAddr, wrEn, wrAddr, wrData, issueEn, issueAddr, flushEn,
    output rdData, rdBusy, busyCount
  );
endinterface

// File: rtl/reg_file_scoreboard.sv
// Multi-ported register file with a per-register busy scoreboard.
//   clk   : sole clock, all state updates on the rising edge
//   rstN  : asynchronous active-low reset, clears data, busy bits and count
//   bus   : slave side of reg_file_scoreboard_if
//           rdAddr/rdData/rdBusy : combinational read ports (optional forwarding)
//           wrEn/wrAddr/wrData   : write ports, highest index wins on conflict
//           issueEn/issueAddr    : mark a destination busy
//           flushEn              : clear all busy bits
//           busyCount            : registered popcount of busy bits
module reg_file_scoreboard #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NRD    = 2,
  parameter int unsigned NWR    = 2,
  parameter int unsigned BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  rstN,
  reg_file_scoreboard_if.slave  bus
);

  localparam int unsigned AW = $clog2(NREGS);
  localparam int unsigned CW = AW + 1;

  logic [XLEN-1:0]     r_regs [NREGS];
  logic [NREGS-1:0]    r_busy;
  logic [CW-1:0]       r_busy_count;

  logic [NREGS-1:0]    w_busy_nxt;
  logic [CW-1:0]       w_busy_count_nxt;
  logic [NRD*XLEN-1:0] w_rd_data;
  logic [NRD-1:0]      w_rd_busy;

  // Register array; later ports overwrite earlier ones so the highest index wins
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (bus.wrEn[j] && (bus.wrAddr[j*AW +: AW] != AW'(0))) begin
          r_regs[bus.wrAddr[j*AW +: AW]] <= bus.wrData[j*XLEN +: XLEN];
        end
      end
    end
  end

  // Busy update order: flush, writeback clears, then issue sets (newest producer wins)
  always_comb begin
    w_busy_nxt = bus.flushEn ? '0 : r_busy;
    for (int j = 0; j < NWR; j++) begin
      if (bus.wrEn[j]) begin
        w_busy_nxt[bus.wrAddr[j*AW +: AW]] = 1'b0;
      end
    end
    if (bus.issueEn) begin
      w_busy_nxt[bus.issueAddr] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Popcount of the next busy vector so the count register tracks the bits exactly
  always_comb begin
    w_busy_count_nxt = '0;
    for (int i = 0; i < NREGS; i++) begin
      w_busy_count_nxt = w_busy_count_nxt + CW'(w_busy_nxt[i]);
    end
  end

  // Scoreboard state
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_busy       <= '0;
      r_busy_count <= '0;
    end else begin
      r_busy       <= w_busy_nxt;
      r_busy_count <= w_busy_count_nxt;
    end
  end

  // Read ports; ascending scan lets the highest matching write port forward last
  always_comb begin
    w_rd_data = '0;
    w_rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      w_rd_data[k*XLEN +: XLEN] = r_regs[bus.rdAddr[k*AW +: AW]];
      w_rd_busy[k]              = r_busy[bus.rdAddr[k*AW +: AW]];
      if (BYPASS != 0) begin
        for (int j = 0; j < NWR; j++) begin
          if (bus.wrEn[j] && (bus.wrAddr[j*AW +: AW] == bus.rdAddr[k*AW +: AW])) begin
            w_rd_data[k*XLEN +: XLEN] = bus.wrData[j*XLEN +: XLEN];
            w_rd_busy[k]              = 1'b0;
          end
        end
      end
      // x0 is hardwired: forwarding a write to it must not leak data
      if (bus.rdAddr[k*AW +: AW] == AW'(0)) begin
        w_rd_data[k*XLEN +: XLEN] = '0;
        w_rd_busy[k]              = 1'b0;
      end
    end
  end

  assign bus.rdData    = w_rd_data;
  assign bus.rdBusy    = w_rd_busy;
  assign bus.busyCount = r_busy_count;

endmodule

// File: doc/reg_file_scoreboard.md
REG_FILE_SCOREBOARD -- requirements
Module: reg_file_scoreboard

Interface
REQ-001 Parameter XLEN, default 32, register data width in bits.
REQ-002 Parameter NREGS, default 32, register count; power of two, >=2; AW = log2(NREGS).
REQ-003 Parameter NRD, default 2, number of read ports.
REQ-004 Parameter NWR, default 2, number of write ports.
REQ-005 Parameter BYPASS, default 1; 1 enables same-cycle write-to-read forwarding, 0 disables it.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rstN  input  1  asynchronous, active-low reset.
REQ-008 rdAddr  input  NRD*AW  read addresses, port k at bits [k*AW +: AW].
REQ-009 rdData  output  NRD*XLEN  read data, port k at bits [k*XLEN +: XLEN].
REQ-010 rdBusy  output  NRD  port k addressed register has a pending producer.
REQ-011 wrEn  input  NWR  per-port write enable.
REQ-012 wrAddr  input  NWR*AW  write addresses.
REQ-013 wrData  input  NWR*XLEN  write data.
REQ-014 issueEn  input  1  mark issueAddr busy (new in-flight producer).
REQ-015 issueAddr  input  AW  destination being issued.
REQ-016 flushEn  input  1  clear all busy bits (pipeline flush).
REQ-017 busyCount  output  AW+1  number of busy registers, registered.

Function
REQ-018 Register 0 SHALL always read 0, ignore all writes, never become busy, never count in busyCount.
REQ-019 Reads SHALL be combinational from the array; rdData/rdBusy change in the same cycle as rdAddr.
REQ-020 Write with wrEn[j]=1 and wrAddr[j]!=0 SHALL update the register at the rising edge.
REQ-021 Multiple write ports on the same address in one cycle: highest-indexed port SHALL win.
REQ-022 Write with wrEn[j]=1 SHALL clear busy for wrAddr[j] at the same edge (writeback retires producer).
REQ-023 BYPASS=1: read address matching an enabled write address this cycle SHALL return the winning wrData combinationally and rdBusy=0 for that port.
REQ-024 BYPASS=0: reads SHALL return pre-edge array contents and stored busy bit.
REQ-025 issueEn=1, issueAddr!=0 SHALL set busy[issueAddr] at the next edge.
REQ-026 Issue and writeback to the same address in one cycle: busy SHALL end set (newer producer wins).
REQ-027 flushEn=1 SHALL clear all busy bits at the next edge; array contents unaffected; same-cycle writes still commit.
REQ-028 flushEn and issueEn in one cycle: busy SHALL end with only busy[issueAddr] set.
REQ-029 Issue to an already-busy register SHALL leave it busy; no error, no count change.
REQ-030 busyCount SHALL equal popcount of busy bits after each edge; max value NREGS-1.

Reset
REQ-031 rstN=0 SHALL immediately clear all registers to 0, all busy bits to 0, busyCount to 0, independent of clk.
REQ-032 Writes, issues and flushes SHALL be ignored while rstN=0; operation resumes at the first rising edge after rstN deasserts.
REQ-033 Reset asserted mid-operation SHALL discard pending state with no partial write.

Verification
REQ-034 Reset: write 0xDEADBEEF to r5, pulse rstN low between edges -> rdData(r5)=0 immediately, busyCount=0.
REQ-035 Write-port conflict: wrEn=2'b11, both addr 7, data 0x11/0x22 -> r7 reads 0x22 next cycle; BYPASS=1 read same cycle returns 0x22.
REQ-036 x0: write 0xFFFFFFFF to r0 and issue r0 -> rdData(r0)=0, rdBusy=0, busyCount unchanged.
REQ-037 Scoreboard: issue r3, r4 (busyCount=2), writeback r3 with issue r3 same cycle -> r3 still busy, busyCount=2; writeback r4 -> busyCount=1.
REQ-038 Flush: with r1..r6 busy, assert flushEn and issue r9 -> next cycle only r9 busy, busyCount=1, register data intact.
REQ-039 BYPASS=0 build: write 0x55 to r2 while reading r2 -> same cycle old value, next cycle 0x55.
